flow_divider_rnd: RTL and testbench

Parametrised successor to the flow-math divider: a fully pipelined, multi-lane signed-by-unsigned integer divider with generic width, selectable rounding, divide-by-zero saturation and ready/valid backpressure. It sits in the JPEG quantisation path, dividing DCT coefficients by quantisation-table entries. It replaces the vendor-macro divider with portable RTL that honours downstream stalls.

---
 rtl/flow_divider_rnd.sv | 159 +++++++++++++++
 tb/tb_flow_divider_rnd.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_divider_rnd.sv
// flow_divider_rnd: pipelined N-lane signed/unsigned divider with rounding,
// divide-by-zero saturation and ready/valid backpressure.
// Ports:
//   clk, rst_n (sync, active-low), en (global clock enable)
//   in_valid/in_ready, in_data[N][DW] signed, in_denom[N][QW] unsigned,
//   in_eob/in_sob/in_sof sideband
//   out_valid/out_ready, out_data[N][DW], out_dz[N], out_eob/out_sob/out_sof
module flow_divider_rnd #(
    parameter int N   = 2,
    parameter int DW  = 16,
    parameter int QW  = 10,
    parameter int BPS = 2,
    parameter int RND = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0][DW-1:0] in_data,
    input  logic [N-1:0][QW-1:0] in_denom,
    input  logic                 in_eob,
    input  logic                 in_sob,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0][DW-1:0] out_data,
    output logic [N-1:0]         out_dz,
    output logic                 out_eob,
    output logic                 out_sob,
    output logic                 out_sof
);

    localparam int S = DW / BPS;

    if (DW % BPS != 0) begin : g_bad_bps
        $error("flow_divider_rnd: DW must be a multiple of BPS");
    end

    // Stage 0 holds |num|; stages 1..S each resolve BPS quotient bits.
    // sr holds the unconsumed numerator bits with quotient bits shifted in.
    logic [S:0]                   v_q,   v_d;
    logic [S:0][2:0]              sb_q,  sb_d;
    logic [S:0][N-1:0]            neg_q, neg_d;
    logic [S:0][N-1:0][DW-1:0]    sr_q,  sr_d;
    logic [S:0][N-1:0][QW-1:0]    rem_q, rem_d;
    logic [S:0][N-1:0][QW-1:0]    den_q, den_d;

    logic                         ov_q;
    logic [N-1:0][DW-1:0]         od_q,  od_d;
    logic [N-1:0]                 odz_q, odz_d;
    logic [2:0]                   osb_q;

    logic                         stall;
    logic [QW-1:0]                r;
    logic [QW:0]                  t;
    logic [DW-1:0]                s;
    logic [DW-1:0]                mag;

    assign stall    = ~en | (ov_q & ~out_ready);
    assign in_ready = ~stall;

    always_comb begin
        v_d   = '0;
        sb_d  = '0;
        neg_d = '0;
        sr_d  = '0;
        rem_d = '0;
        den_d = '0;
        r     = '0;
        t     = '0;
        s     = '0;

        v_d[0]  = in_valid;
        sb_d[0] = in_valid ? {in_eob, in_sob, in_sof} : 3'b000;
        for (int i = 0; i < N; i++) begin
            neg_d[0][i] = in_data[i][DW-1];
            sr_d[0][i]  = in_data[i][DW-1] ? -in_data[i] : in_data[i];
            den_d[0][i] = in_denom[i];
        end

        for (int j = 1; j <= S; j++) begin
            v_d[j]   = v_q[j-1];
            sb_d[j]  = sb_q[j-1];
            neg_d[j] = neg_q[j-1];
            den_d[j] = den_q[j-1];
            for (int i = 0; i < N; i++) begin
                r = rem_q[j-1][i];
                s = sr_q[j-1][i];
                for (int b = 0; b < BPS; b++) begin
                    // Restoring step on a QW+1 bit partial remainder.
                    t = {r, s[DW-1]};
                    s = {s[DW-2:0], 1'b0};
                    if (t >= {1'b0, den_q[j-1][i]}) begin
                        t    = t - {1'b0, den_q[j-1][i]};
                        s[0] = 1'b1;
                    end
                    r = t[QW-1:0];
                end
                rem_d[j][i] = r;
                sr_d[j][i]  = s;
            end
        end
    end

    always_comb begin
        od_d  = '0;
        odz_d = '0;
        mag   = '0;
        for (int i = 0; i < N; i++) begin
            mag = sr_q[S][i];
            // Round on magnitude so the sign gives half-away-from-zero.
            if (RND != 0 &&
                {rem_q[S][i], 1'b0} >= {1'b0, den_q[S][i]}) begin
                mag = mag + DW'(1);
            end
            od_d[i] = neg_q[S][i] ? -mag : mag;
            if (den_q[S][i] == '0) begin
                odz_d[i] = v_q[S];
                od_d[i]  = neg_q[S][i] ? {1'b1, {(DW-1){1'b0}}}
                                       : {1'b0, {(DW-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            sb_q  <= '0;
            neg_q <= '0;
            sr_q  <= '0;
            rem_q <= '0;
            den_q <= '0;
            ov_q  <= 1'b0;
            od_q  <= '0;
            odz_q <= '0;
            osb_q <= '0;
        end else if (!stall) begin
            v_q   <= v_d;
            sb_q  <= sb_d;
            neg_q <= neg_d;
            sr_q  <= sr_d;
            rem_q <= rem_d;
            den_q <= den_d;
            ov_q  <= v_q[S];
            od_q  <= od_d;
            odz_q <= odz_d;
            osb_q <= sb_q[S];
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_dz    = odz_q;
    assign out_eob   = osb_q[2];
    assign out_sob   = osb_q[1];
    assign out_sof   = osb_q[0];

endmodule

// File: tb/tb_flow_divider_rnd.sv
// tb_flow_divider_rnd: scoreboard bench driving a rounding and a
// truncating instance of flow_divider_rnd in lockstep.
module tb_flow_divider_rnd;

    localparam int N   = 2;
    localparam int DW  = 16;
    localparam int QW  = 10;
    localparam int BPS = 2;
    localparam int L   = DW / BPS + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, en, in_valid, out_ready;
    logic [N-1:0][DW-1:0] in_data;
    logic [N-1:0][QW-1:0] in_denom;
    logic                 in_eob, in_sob, in_sof;

    logic                 in_ready1, out_valid1;
    logic [N-1:0][DW-1:0] out_data1;
    logic [N-1:0]         out_dz1;
    logic                 out_eob1, out_sob1, out_sof1;
    logic                 in_ready0, out_valid0;
    logic [N-1:0][DW-1:0] out_data0;
    logic [N-1:0]         out_dz0;
    logic                 out_eob0, out_sob0, out_sof0;

    flow_divider_rnd #(.N(N), .DW(DW), .QW(QW), .BPS(BPS), .RND(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_denom(in_denom),
        .in_eob(in_eob), .in_sob(in_sob), .in_sof(in_sof),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_dz(out_dz1),
        .out_eob(out_eob1), .out_sob(out_sob1), .out_sof(out_sof1)
    );

    flow_divider_rnd #(.N(N), .DW(DW), .QW(QW), .BPS(BPS), .RND(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_denom(in_denom),
        .in_eob(in_eob), .in_sob(in_sob), .in_sof(in_sof),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_dz(out_dz0),
        .out_eob(out_eob0), .out_sob(out_sob0), .out_sof(out_sof0)
    );

    typedef struct {
        int         r1_0, r1_1, r0_0, r0_1;
        logic [1:0] dz;
        logic [2:0] sb;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int ref_div(input int a, input int d, input bit rnd);
        int q, r;
        if (d == 0) return (a >= 0) ? 32767 : -32768;
        q = a / d;
        r = a % d;
        if (r < 0) r = -r;
        if (rnd && 2 * r >= d) q = (a < 0) ? q - 1 : q + 1;
        return q;
    endfunction

    task automatic drive_ctl();
        en = 1'b1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic issue(input int a0, input int q0, input int a1,
                         input int q1, input int r1_0, input int r1_1,
                         input int r0_0, input int r0_1,
                         input logic [1:0] dz, input logic [2:0] sb,
                         input int lat);
        exp_t e;
        bit   done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            drive_ctl();
            in_valid    = 1'b1;
            in_data[0]  = 16'(a0);
            in_denom[0] = 10'(q0);
            in_data[1]  = 16'(a1);
            in_denom[1] = 10'(q1);
            {in_eob, in_sob, in_sof} = sb;
            #1;
            if (in_ready1) begin
                e.r1_0 = r1_0; e.r1_1 = r1_1;
                e.r0_0 = r0_0; e.r0_1 = r0_1;
                e.dz = dz; e.sb = sb;
                e.acc = cyc + 1;
                e.lat = lat;
                sbq.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got 0 expected 1");
        end
    endtask

    task automatic issue_m(input int a0, input int q0, input int a1,
                           input int q1, input logic [2:0] sb,
                           input int lat);
        issue(a0, q0, a1, q1,
              ref_div(a0, q0, 1'b1), ref_div(a1, q1, 1'b1),
              ref_div(a0, q0, 1'b0), ref_div(a1, q1, 1'b0),
              {q1 == 0, q0 == 0}, sb, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_ctl();
            in_valid = 1'b0;
            {in_eob, in_sob, in_sof} = 3'b000;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 800 && sbq.size() != 0; t++) idle(1);
        idle(2);
        chk("drain_empty", sbq.size(), 0);
    endtask

    // Monitor: pops on every consumed beat, checks hold-stability on stalls.
    logic [2*N*DW+2*N+5:0] snap, hold;
    bit   held = 1'b0;
    bit   pres = 1'b0;
    int   first = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            snap = {out_data1, out_data0, out_dz1, out_dz0,
                    out_eob1, out_sob1, out_sof1,
                    out_eob0, out_sob0, out_sof0};
            if (!rst_n) begin
                held = 1'b0;
                pres = 1'b0;
            end else if (out_valid1) begin
                if (!pres) begin
                    pres  = 1'b1;
                    first = cyc;
                end
                if (held) begin
                    checks++;
                    if (snap !== hold) begin
                        errors++;
                        $display("FAIL stall_stable got %h expected %h",
                                 snap, hold);
                    end
                end
                if (out_ready && en) begin
                    held = 1'b0;
                    pres = 1'b0;
                    chk("valid_rnd0", int'(out_valid0), 1);
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat got %0d expected none",
                                 $signed(out_data1[0]));
                    end else begin
                        e = sbq.pop_front();
                        chk("rnd1_lane0", $signed(out_data1[0]), e.r1_0);
                        chk("rnd1_lane1", $signed(out_data1[1]), e.r1_1);
                        chk("rnd0_lane0", $signed(out_data0[0]), e.r0_0);
                        chk("rnd0_lane1", $signed(out_data0[1]), e.r0_1);
                        chk("dz_rnd1", int'(out_dz1), int'(e.dz));
                        chk("dz_rnd0", int'(out_dz0), int'(e.dz));
                        chk("sb_rnd1", int'({out_eob1, out_sob1, out_sof1}),
                            int'(e.sb));
                        chk("sb_rnd0", int'({out_eob0, out_sob0, out_sof0}),
                            int'(e.sb));
                        if (e.lat >= 0) chk("latency", first - e.acc, e.lat);
                    end
                end else begin
                    hold = snap;
                    held = 1'b1;
                end
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_valid1"}, int'(out_valid1), 0);
        chk({nm, "_valid0"}, int'(out_valid0), 0);
        chk({nm, "_data1"}, int'(out_data1), 0);
        chk({nm, "_data0"}, int'(out_data0), 0);
        chk({nm, "_dz"}, int'({out_dz1, out_dz0}), 0);
        chk({nm, "_sb"}, int'({out_eob1, out_sob1, out_sof1,
                               out_eob0, out_sob0, out_sof0}), 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        in_data = '0; in_denom = '0;
        in_eob = 1'b0; in_sob = 1'b0; in_sof = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("in_ready_en1", int'(in_ready1), 1);
        en = 1'b0;
        #1;
        chk("in_ready_en0_reset", int'(in_ready1), 0);
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back to back, hand-computed results.
        issue(100, 7, -100, 7, 14, -14, 14, -14, 2'b00, 3'b011, L - 1);
        issue(-7, 2, 7, 2, -4, 4, -3, 3, 2'b00, 3'b010, L - 1);
        issue(32767, 1023, -32768, 1, 32, -32768, 32, -32768,
              2'b00, 3'b000, L - 1);
        issue(5, 0, -5, 3, 32767, -2, 32767, -1, 2'b01, 3'b000, L - 1);
        issue(-5, 0, 0, 0, -32768, 32767, -32768, 32767,
              2'b11, 3'b000, L - 1);
        issue(512, 1023, 511, 1023, 1, 0, 0, 0, 2'b00, 3'b000, L - 1);
        issue(-32768, 1023, 3, 2, -32, 2, -32, 1, 2'b00, 3'b100, L - 1);
        issue(32767, 1, -32768, 2, 32767, -16384, 32767, -16384,
              2'b00, 3'b000, L - 1);
        drain();

        // Clock-enable freeze with four beats in flight.
        for (int i = 0; i < 4; i++)
            issue_m(300 * i - 555, 3 + i, 999 - 77 * i, 5 + 2 * i,
                    3'b000, L - 1 + 3);
        repeat (3) begin
            @(negedge clk);
            en = 1'b0;
            out_ready = 1'b1;
            in_valid = 1'b1;
            in_data[0] = 16'h1234;
            in_denom[0] = 10'd9;
            #1;
            chk("in_ready_en0", int'(in_ready1), 0);
        end
        issue_m(-4321, 17, 4321, 18, 3'b000, L - 1);
        issue_m(250, 100, -250, 100, 3'b100, L - 1);
        drain();

        // Random backpressure stream with eob on every 4th beat.
        bp = 1'b1;
        for (int i = 0; i < 20; i++)
            issue_m(i * 1733 - 16000, (i * 53) % 1024,
                    12000 - i * 1291, i * 7 + 1,
                    {(i % 4) == 3, 2'b00}, -1);
        drain();
        bp = 1'b0;

        // Reset with five beats in flight.
        for (int i = 0; i < 5; i++)
            issue_m(1000 + i, 3, -2000 - i, 7, 3'b000, -1);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
        #1;
        chk_zero("midreset");
        idle(2 * L);
        issue(-100, 7, 7, 2, -14, 4, -14, 3, 2'b00, 3'b001, L - 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
